// File: rtl/apb_pkg.sv
// apb_pkg: shared APB master types, default widths and the UART decode base
//   state_e        : arbiter FSM states
//   APB_*_WIDTH    : default address/data widths
//   STB_WIDTH      : byte-strobe width
//   UART_BASE      : single address decoded to the UART, everything else is SRAM
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int STB_WIDTH = 4;
    localparam logic [31:0] UART_BASE = 32'h0100_0000;
endpackage

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin share of one APB master port between fetch (port 0) and load/store (port 1)
//   pclk/presetn            : clock, synchronous active-low reset
//   reqN_valid/addr/wdata/write/stb : requester N command, sampled in IDLE only
//   reqN_ack/done/rdata/err : latch pulse, completion pulse, read data and error status
//   paddr/pdata/pwrite/pstb/psel/penable : APB master outputs
//   prdata/pready/perr      : APB slave responses
//   TIMEOUT                 : ACCESS cycles allowed before a forced error, 0 disables
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_write,
    input  logic [STB_WIDTH-1:0]  req0_stb,
    output logic                  req0_ack,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_write,
    input  logic [STB_WIDTH-1:0]  req1_stb,
    output logic                  req1_ack,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [STB_WIDTH-1:0]  pstb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [STB_WIDTH-1:0]  pstb_q, pstb_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  win, tmo;
    logic [DATA_WIDTH-1:0] rd;
    // last_q doubles as the grant of the transfer in flight
    assign win = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST) && !pready;
    assign rd = pready ? prdata : '0;
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        cnt_d = cnt_q;
        paddr_d = paddr_q;
        pdata_d = pdata_q;
        pwrite_d = pwrite_q;
        pstb_d = pstb_q;
        done_d = '0;
        err_d = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    last_d = win;
                    paddr_d = win ? req1_addr : req0_addr;
                    pdata_d = win ? req1_wdata : req0_wdata;
                    pwrite_d = win ? req1_write : req0_write;
                    pstb_d = win ? req1_stb : req0_stb;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready || tmo) begin
                    state_d = IDLE;
                    done_d[last_q] = 1'b1;
                    err_d[last_q] = pready ? perr : 1'b1;
                    rdata0_d = last_q ? rdata0_q : rd;
                    rdata1_d = last_q ? rd : rdata1_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= IDLE;
            last_q <= 1'b1;
            cnt_q <= '0;
            paddr_q <= '0;
            pdata_q <= '0;
            pwrite_q <= 1'b0;
            pstb_q <= '0;
            done_q <= '0;
            err_q <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            paddr_q <= paddr_d;
            pdata_q <= pdata_d;
            pwrite_q <= pwrite_d;
            pstb_q <= pstb_d;
            done_q <= done_d;
            err_q <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
    assign psel = state_q != IDLE;
    assign penable = state_q == ACCESS;
    assign req0_ack = (state_q == SETUP) && !last_q;
    assign req1_ack = (state_q == SETUP) && last_q;
    assign req0_done = done_q[0];
    assign req1_done = done_q[1];
    assign req0_err = err_q[0];
    assign req1_err = err_q[1];
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign paddr = paddr_q;
    assign pdata = pdata_q;
    assign pwrite = pwrite_q;
    assign pstb = pstb_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scoreboard bench for apb_master_arbiter with TIMEOUT=4
module tb_apb_master_arbiter;
    import apb_pkg::*;
    logic pclk = 1'b0, presetn = 1'b0;
    logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
    logic [3:0] req0_stb = '0, req1_stb = '0;
    logic req0_ack, req0_done, req0_err, req1_ack, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata, paddr, pdata, prdata;
    logic pwrite, psel, penable, pready, perr;
    logic [3:0] pstb;
    int vectors = 0, miscompares = 0;
    typedef struct {logic port; logic [31:0] rdata; logic err;} exp_t;
    exp_t sb[$];
    logic gq[$];
    logic [7:0] acc_cnt = '0;
    int slave_wait = 0;
    logic slave_hang = 1'b0, slave_err = 1'b0;
    logic [31:0] slave_rdata = '0;
    int n;
    apb_master_arbiter #(.TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_write(req0_write), .req0_stb(req0_stb), .req0_ack(req0_ack),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_write(req1_write), .req1_stb(req1_stb), .req1_ack(req1_ack),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .paddr(paddr), .pdata(pdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pstb(pstb), .prdata(prdata), .pready(pready), .perr(perr)
    );
    always #5 pclk = ~pclk;
    always @(posedge pclk) acc_cnt <= (penable && !pready) ? acc_cnt + 8'd1 : 8'd0;
    assign pready = penable && !slave_hang && (int'(acc_cnt) >= slave_wait);
    assign prdata = slave_rdata;
    assign perr = slave_err;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic cycle();
        exp_t e;
        logic g;
        @(posedge pclk);
        #1;
        if (req0_ack || req1_ack) begin
            chk("ack_both", 64'(req0_ack & req1_ack), 64'(0));
            if (gq.size() > 0) begin
                g = gq.pop_front();
                chk("grant_order", 64'(req1_ack), 64'(g));
            end else chk("unexpected_ack", 64'({req0_ack, req1_ack}), 64'(0));
        end
        if (req0_done || req1_done) begin
            if (sb.size() == 0) chk("unexpected_done", 64'({req0_done, req1_done}), 64'(0));
            else begin
                e = sb.pop_front();
                chk("done_port", 64'({req0_done, req1_done}), e.port ? 64'(2'b01) : 64'(2'b10));
                chk("done_rdata", 64'(e.port ? req1_rdata : req0_rdata), 64'(e.rdata));
                chk("done_err", 64'(e.port ? req1_err : req0_err), 64'(e.err));
            end
        end
    endtask
    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
        chk("drain_empty", 64'(sb.size()), 64'(0));
    endtask
    task automatic chk_reset_state(input string tag);
        chk(tag, 64'({psel, penable, pwrite, pstb, req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err}), 64'(0));
        chk({tag, "_paddr"}, 64'(paddr), 64'(0));
        chk({tag, "_pdata"}, 64'(pdata), 64'(0));
        chk({tag, "_rdata"}, {req0_rdata, req1_rdata}, 64'(0));
    endtask
    task automatic do_reset();
        presetn = 1'b0;
        cycle();
        cycle();
        presetn = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset();
        chk_reset_state("reset");
        // single zero-wait read on port 0
        slave_rdata = 32'hDEAD_BEEF;
        req0_valid = 1'b1; req0_addr = 32'h100; req0_write = 1'b0; req0_stb = 4'hF;
        sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0}); gq.push_back(1'b0);
        chk("rd_c0_psel", 64'(psel), 64'(0));
        cycle();
        req0_valid = 1'b0;
        chk("rd_c1_ctrl", 64'({psel, penable}), 64'(2'b10));
        chk("rd_c1_paddr", 64'({pwrite, paddr}), 64'(32'h100));
        cycle();
        chk("rd_c2_ctrl", 64'({psel, penable}), 64'(2'b11));
        cycle();
        chk("rd_c3_done", 64'({req0_done, psel}), 64'(2'b10));
        chk("rd_sb", 64'(sb.size()), 64'(0));
        // port 1 write to UART with three wait states
        slave_wait = 3; slave_rdata = 32'h0BAD_0001;
        req1_valid = 1'b1; req1_addr = UART_BASE; req1_wdata = 32'hA5; req1_write = 1'b1; req1_stb = 4'b0001;
        sb.push_back('{1'b1, 32'h0BAD_0001, 1'b0}); gq.push_back(1'b1);
        cycle();
        req1_valid = 1'b0; req1_addr = 32'hFFFF_FFFF; req1_wdata = '0; req1_stb = 4'hF;
        chk("wr_setup", 64'({psel, penable}), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("wr_stable", 64'({pwrite, pstb, paddr}), 64'({1'b1, 4'b0001, UART_BASE}));
            chk("wr_pdata", 64'(pdata), 64'(32'hA5));
            chk("wr_access_nodone", 64'({penable, req1_done}), 64'(2'b10));
        end
        cycle();
        chk("wr_done", 64'(req1_done), 64'(1));
        // contention right after reset: 0,1,0,1
        do_reset();
        slave_wait = 0; slave_rdata = 32'h1111_0000;
        req0_valid = 1'b1; req0_addr = 32'h200; req0_write = 1'b0;
        req1_valid = 1'b1; req1_addr = 32'h300; req1_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gq.push_back(1'(i % 2));
            sb.push_back('{1'(i % 2), 32'h1111_0000, 1'b0});
        end
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (gq.size() == 0) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        drain(10);
        chk("cont_grants", 64'(gq.size()), 64'(0));
        // timeout with a slave that never answers
        slave_hang = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h400;
        sb.push_back('{1'b0, 32'h0, 1'b1}); gq.push_back(1'b0);
        cycle();
        req0_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!penable) break;
            n++;
        end
        chk("tmo_access_cycles", 64'(n), 64'(4));
        chk("tmo_idle", 64'(psel), 64'(0));
        chk("tmo_sb", 64'(sb.size()), 64'(0));
        slave_hang = 1'b0;
        // slave error on completion
        slave_err = 1'b1; slave_rdata = 32'hCAFE_F00D;
        req1_valid = 1'b1; req1_addr = 32'h500; req1_write = 1'b0;
        sb.push_back('{1'b1, 32'hCAFE_F00D, 1'b1}); gq.push_back(1'b1);
        cycle();
        req1_valid = 1'b0;
        drain(10);
        slave_err = 1'b0;
        // reset during the second ACCESS cycle
        slave_wait = 5;
        req1_valid = 1'b1; req1_addr = 32'h600;
        gq.push_back(1'b1);
        cycle();
        req1_valid = 1'b0;
        cycle();
        cycle();
        chk("rst_in_access", 64'(penable), 64'(1));
        presetn = 1'b0;
        cycle();
        chk_reset_state("rst_mid");
        presetn = 1'b1;
        slave_wait = 0; slave_rdata = 32'h0000_600D;
        req0_valid = 1'b1; req0_addr = 32'h700; req1_valid = 1'b1;
        gq.push_back(1'b0);
        sb.push_back('{1'b0, 32'h0000_600D, 1'b0});
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rst_tie_ack", 64'({req0_ack, req1_ack}), 64'(2'b10));
        drain(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
